audio_codec_controller: RTL and testbench
=========================================

Name: audio_codec_controller

Overview:
- Serial audio interface between fabric logic and the board's audio codec (WM8731-class), with the codec as bus master generating AUD_BCLK, AUD_ADCLRCK and AUD_DACLRCK.
- Deserialises ADC frames into an input FIFO and serialises DAC frames from an output FIFO.
- Generates the codec master clock AUD_XCK.
- Codec register setup over I2C is handled by a separate configuration block and is out of scope here.

Parameters:
- AUDIO_DATA_WIDTH, 32: bits per channel sample, MSB first on the serial lines.
- FIFO_DEPTH, 8: stereo frames per FIFO; must be a power of 2, minimum 2.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; all logic runs in this domain.
- reset  in  1  asynchronous, active-low reset.
- clear_audio_in_memory  in  1  synchronous flush of the input FIFO.
- read_audio_in  in  1  pop the head frame of the input FIFO.
- clear_audio_out_memory  in  1  synchronous flush of the output FIFO.
- left_channel_audio_out  in  AUDIO_DATA_WIDTH  left sample to enqueue.
- right_channel_audio_out  in  AUDIO_DATA_WIDTH  right sample to enqueue.
- write_audio_out  in  1  push {left, right} into the output FIFO.
- AUD_ADCDAT  in  1  codec ADC serial data.
- AUD_BCLK  inout  1  bit clock; never driven (output enable tied 0), read as input.
- AUD_ADCLRCK  inout  1  ADC word clock; never driven, read as input.
- AUD_DACLRCK  inout  1  DAC word clock; never driven, read as input.
- audio_in_available  out  1  input FIFO not empty.
- left_channel_audio_in  out  AUDIO_DATA_WIDTH  head-of-FIFO left sample (show-ahead).
- right_channel_audio_in  out  AUDIO_DATA_WIDTH  head-of-FIFO right sample (show-ahead).
- audio_out_allowed  out  1  output FIFO not full.
- AUD_XCK  out  1  codec master clock, CLOCK_50/4 = 12.5 MHz, 50% duty.
- AUD_DACDAT  out  1  codec DAC serial data.

Behaviour:
- Reset (reset = 0, asynchronous):
  - Both FIFOs empty; audio_in_available = 0; audio_out_allowed = 1.
  - Data outputs = 0; AUD_DACDAT = 0; AUD_XCK = 0.
  - Shift registers and bit counters cleared.
- Synchronisation and edge detection:
  - AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK and AUD_ADCDAT each pass through 2-FF synchronisers.
  - BCLK rising/falling edges and LRCK edges are detected in the CLOCK_50 domain.
- Serial format (I2S):
  - LRCK low = left channel, high = right channel.
  - The MSB appears on the second BCLK rising edge after an LRCK transition.
  - Receive samples ADCDAT on BCLK rising edges; transmit updates DACDAT on BCLK falling edges.
- ADC path:
  - After each ADCLRCK edge, skip one bit, then shift in up to AUDIO_DATA_WIDTH bits MSB first.
  - If the next LRCK edge arrives first, the unfilled LSBs are 0; extra bits beyond AUDIO_DATA_WIDTH are ignored.
  - On each ADCLRCK falling edge, the completed {left, right} frame is pushed into the input FIFO.
  - If the input FIFO is full, the new frame is dropped and FIFO contents are unchanged.
  - No frame is pushed until one complete left+right pair has been captured after reset or flush.
- DAC path:
  - On each DACLRCK falling edge, if the output FIFO is non-empty, pop one frame into the left/right transmit registers; if empty, load zeros (underrun outputs silence).
  - Each channel is shifted out MSB first starting one bit after its LRCK edge, then AUD_DACDAT = 0 until the next edge.
- Input FIFO read interface:
  - read_audio_in while audio_in_available = 1 pops the head frame; the new head (or 0 when empty) is visible on the next cycle.
  - read_audio_in while empty is ignored.
  - A push and a pop in the same cycle on a full FIFO are both accepted.
- Output FIFO write interface:
  - write_audio_out while audio_out_allowed = 1 pushes one frame.
  - write_audio_out while full is ignored.
  - Flags update on the cycle after the push/pop.
- Flush:
  - clear_* empties the corresponding FIFO on the next edge and has priority over a same-cycle push or pop.
  - Serial shifting is not interrupted by a flush.
- AUD_XCK is a free-running divide-by-4 toggle, independent of the FIFOs.

Optional Feature:
- AUDIO_OVERRUN_FLAG_EN, when defined:
  - Adds output audio_in_overrun (1 bit): a sticky flag set when an ADC frame is dropped because the input FIFO is full.
  - Cleared by reset or clear_audio_in_memory.
- When undefined: the port is absent and dropped frames go unreported.

Test Plan:
- Reset asserted mid-frame -> immediately audio_in_available = 0, audio_out_allowed = 1, AUD_DACDAT = 0; after release, AUD_XCK period = 4 CLOCK_50 cycles.
- Codec model sends left = 32'h12345678, right = 32'h9ABCDEF0 in one I2S frame -> after the ADCLRCK falling edge, audio_in_available = 1 with those values on the outputs; read_audio_in for 1 cycle -> available = 0 next cycle.
- Write left = 32'hA5A5A5A5, right = 32'h0F0F0F0F -> next DAC frame shows those bits MSB first on AUD_DACDAT; the following frame with the FIFO empty sends all zeros.
- Write 8 frames without reads -> audio_out_allowed = 0; a 9th write is ignored; the serialiser emits exactly frames 1..8 in order.
- Feed 9 ADC frames with no reads -> FIFO holds frames 1..8, frame 9 is dropped (audio_in_overrun = 1 when AUDIO_OVERRUN_FLAG_EN is defined).
- Assert clear_audio_in_memory with a full FIFO and read_audio_in high in the same cycle -> FIFO empty next cycle, audio_in_available = 0, overrun flag cleared.

Source files
------------

// File: rtl/audio_codec_controller.sv
// I2S slave bridge to a WM8731-class codec: ADC/DAC FIFOs, serialisers, XCK.
// Optional sticky ADC overrun output enabled by defining AUDIO_OVERRUN_FLAG_EN.
module audio_codec_controller #(
    parameter int AUDIO_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH       = 8
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic                        clear_audio_in_memory,
    input  logic                        read_audio_in,
    input  logic                        clear_audio_out_memory,
    input  logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio_out,
    input  logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio_out,
    input  logic                        write_audio_out,
    input  logic                        AUD_ADCDAT,
    inout  wire                         AUD_BCLK,
    inout  wire                         AUD_ADCLRCK,
    inout  wire                         AUD_DACLRCK,
    output logic                        audio_in_available,
    output logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio_in,
    output logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio_in,
    output logic                        audio_out_allowed,
`ifdef AUDIO_OVERRUN_FLAG_EN
    output logic                        audio_in_overrun,
`endif
    output logic                        AUD_XCK,
    output logic                        AUD_DACDAT
);

    localparam int W  = AUDIO_DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam int IW = $clog2(W);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;

    localparam logic [NW-1:0] FULL_N = NW'(FIFO_DEPTH);
    localparam logic [CW-1:0] W_N    = CW'(W);
    localparam logic [IW-1:0] TOP    = IW'(W - 1);

    logic [2:0] bclk_q;
    logic [2:0] adcl_q;
    logic [2:0] dacl_q;
    logic [1:0] adcdat_q;

    logic bclk_rise;
    logic bclk_fall;
    logic adc_rise;
    logic adc_fall;
    logic adc_edge;
    logic dac_fall;
    logic dac_edge;

    logic [W-1:0]  adc_sr;
    logic [W-1:0]  adc_left;
    logic [CW-1:0] adc_cnt;
    logic          adc_skip;
    logic          adc_seen;
    logic          adc_pair;
    logic          adc_push;

    logic [2*W-1:0] in_mem [FIFO_DEPTH];
    logic [PW-1:0]  in_wr;
    logic [PW-1:0]  in_rd;
    logic [NW-1:0]  in_count;
    logic           in_push;
    logic           in_pop;

    logic [2*W-1:0] out_mem [FIFO_DEPTH];
    logic [PW-1:0]  out_wr;
    logic [PW-1:0]  out_rd;
    logic [NW-1:0]  out_count;
    logic           out_push;
    logic           out_pop;

    logic [W-1:0]  tx_left;
    logic [W-1:0]  tx_right;
    logic [W-1:0]  dac_word;
    logic [CW-1:0] dac_cnt;

    logic [1:0] xck_div;

    // Two-flop synchronisers plus one history stage for edge detection
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            bclk_q   <= '0;
            adcl_q   <= '0;
            dacl_q   <= '0;
            adcdat_q <= '0;
        end else begin
            bclk_q   <= {bclk_q[1:0], AUD_BCLK};
            adcl_q   <= {adcl_q[1:0], AUD_ADCLRCK};
            dacl_q   <= {dacl_q[1:0], AUD_DACLRCK};
            adcdat_q <= {adcdat_q[0], AUD_ADCDAT};
        end
    end

    assign bclk_rise = bclk_q[1] & ~bclk_q[2];
    assign bclk_fall = ~bclk_q[1] & bclk_q[2];
    assign adc_rise  = adcl_q[1] & ~adcl_q[2];
    assign adc_fall  = ~adcl_q[1] & adcl_q[2];
    assign adc_edge  = adc_rise | adc_fall;
    assign dac_fall  = ~dacl_q[1] & dacl_q[2];
    assign dac_edge  = dacl_q[1] ^ dacl_q[2];

    // ADC deserialiser: skip one bit after each word-clock edge, fill MSB first
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            adc_sr   <= '0;
            adc_left <= '0;
            adc_cnt  <= '0;
            adc_skip <= 1'b1;
            adc_seen <= 1'b0;
            adc_pair <= 1'b0;
        end else begin
            if (adc_edge) begin
                adc_sr   <= '0;
                adc_cnt  <= '0;
                adc_skip <= 1'b1;
                if (adc_rise) begin
                    adc_left <= adc_sr;
                end
            end else if (bclk_rise) begin
                if (adc_skip) begin
                    adc_skip <= 1'b0;
                end else if (adc_cnt < W_N) begin
                    adc_sr[TOP - adc_cnt[IW-1:0]] <= adcdat_q[1];
                    adc_cnt <= adc_cnt + CW'(1);
                end
            end
            if (clear_audio_in_memory) begin
                adc_seen <= 1'b0;
                adc_pair <= 1'b0;
            end else if (adc_fall) begin
                adc_seen <= 1'b1;
                adc_pair <= 1'b0;
            end else if (adc_rise) begin
                adc_pair <= adc_seen;
            end
        end
    end

    // A frame is complete only when a full left slot preceded this right slot
    assign adc_push = adc_fall & adc_pair;
    assign in_pop   = read_audio_in & (in_count != '0)
                    & ~clear_audio_in_memory;
    assign in_push  = adc_push & ((in_count != FULL_N) | in_pop)
                    & ~clear_audio_in_memory;

    // Input FIFO pointers and occupancy; flush wins over push and pop
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            in_wr    <= '0;
            in_rd    <= '0;
            in_count <= '0;
        end else if (clear_audio_in_memory) begin
            in_wr    <= '0;
            in_rd    <= '0;
            in_count <= '0;
        end else begin
            if (in_push) begin
                in_wr <= in_wr + PW'(1);
            end
            if (in_pop) begin
                in_rd <= in_rd + PW'(1);
            end
            if (in_push && !in_pop) begin
                in_count <= in_count + NW'(1);
            end else if (!in_push && in_pop) begin
                in_count <= in_count - NW'(1);
            end
        end
    end

    // Input FIFO storage
    always_ff @(posedge CLOCK_50) begin
        if (in_push) begin
            in_mem[in_wr] <= {adc_left, adc_sr};
        end
    end

    assign audio_in_available = (in_count != '0);
    assign {left_channel_audio_in, right_channel_audio_in} =
        audio_in_available ? in_mem[in_rd] : '0;

`ifdef AUDIO_OVERRUN_FLAG_EN
    logic in_drop;
    assign in_drop = adc_push & ~in_push & ~clear_audio_in_memory;

    // Sticky record of an ADC frame lost to a full input FIFO
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            audio_in_overrun <= 1'b0;
        end else if (clear_audio_in_memory) begin
            audio_in_overrun <= 1'b0;
        end else if (in_drop) begin
            audio_in_overrun <= 1'b1;
        end
    end
`endif

    assign out_push = write_audio_out & (out_count != FULL_N)
                    & ~clear_audio_out_memory;
    assign out_pop  = dac_fall & (out_count != '0)
                    & ~clear_audio_out_memory;

    // Output FIFO pointers and occupancy; flush wins over push and pop
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            out_wr    <= '0;
            out_rd    <= '0;
            out_count <= '0;
        end else if (clear_audio_out_memory) begin
            out_wr    <= '0;
            out_rd    <= '0;
            out_count <= '0;
        end else begin
            if (out_push) begin
                out_wr <= out_wr + PW'(1);
            end
            if (out_pop) begin
                out_rd <= out_rd + PW'(1);
            end
            if (out_push && !out_pop) begin
                out_count <= out_count + NW'(1);
            end else if (!out_push && out_pop) begin
                out_count <= out_count - NW'(1);
            end
        end
    end

    // Output FIFO storage
    always_ff @(posedge CLOCK_50) begin
        if (out_push) begin
            out_mem[out_wr] <= {left_channel_audio_out, right_channel_audio_out};
        end
    end

    assign audio_out_allowed = (out_count != FULL_N);
    assign dac_word = dacl_q[1] ? tx_right : tx_left;

    // DAC serialiser: load on word-clock fall, drive one bit per BCLK fall
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            tx_left    <= '0;
            tx_right   <= '0;
            dac_cnt    <= '0;
            AUD_DACDAT <= 1'b0;
        end else if (dac_edge) begin
            dac_cnt    <= '0;
            AUD_DACDAT <= 1'b0;
            if (dac_fall) begin
                {tx_left, tx_right} <= out_pop ? out_mem[out_rd] : '0;
            end
        end else if (bclk_fall) begin
            if (dac_cnt < W_N) begin
                AUD_DACDAT <= dac_word[TOP - dac_cnt[IW-1:0]];
                dac_cnt    <= dac_cnt + CW'(1);
            end else begin
                AUD_DACDAT <= 1'b0;
            end
        end
    end

    // Free-running divide-by-4 master clock
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            xck_div <= '0;
        end else begin
            xck_div <= xck_div + 2'd1;
        end
    end

    assign AUD_XCK = xck_div[1];

endmodule

// File: tb/tb_audio_codec_controller.sv
// Randomised bench for audio_codec_controller with a codec bus-master model
// and queue-based scoreboards for both FIFOs and the DAC serial stream.
module tb_audio_codec_controller;

    localparam int W = 32;
    localparam int D = 8;
    localparam int H = 8;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic         rst_n;
    logic         clear_in;
    logic         read_in_r;
    logic         clear_out;
    logic [W-1:0] out_l;
    logic [W-1:0] out_r;
    logic         write_out_r;
    logic         adcdat_d;
    logic         bclk_d;
    logic         adclrck_d;
    logic         daclrck_d;

    wire aud_bclk;
    wire aud_adclrck;
    wire aud_daclrck;
    assign aud_bclk    = bclk_d;
    assign aud_adclrck = adclrck_d;
    assign aud_daclrck = daclrck_d;

    logic         avail;
    logic [W-1:0] in_l;
    logic [W-1:0] in_r;
    logic         allowed;
    logic         xck;
    logic         dacdat;
`ifdef AUDIO_OVERRUN_FLAG_EN
    logic         overrun;
`endif

    audio_codec_controller #(
        .AUDIO_DATA_WIDTH(W),
        .FIFO_DEPTH(D)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst_n),
        .clear_audio_in_memory(clear_in),
        .read_audio_in(read_in_r),
        .clear_audio_out_memory(clear_out),
        .left_channel_audio_out(out_l),
        .right_channel_audio_out(out_r),
        .write_audio_out(write_out_r),
        .AUD_ADCDAT(adcdat_d),
        .AUD_BCLK(aud_bclk),
        .AUD_ADCLRCK(aud_adclrck),
        .AUD_DACLRCK(aud_daclrck),
        .audio_in_available(avail),
        .left_channel_audio_in(in_l),
        .right_channel_audio_in(in_r),
        .audio_out_allowed(allowed),
`ifdef AUDIO_OVERRUN_FLAG_EN
        .audio_in_overrun(overrun),
`endif
        .AUD_XCK(xck),
        .AUD_DACDAT(dacdat)
    );

    int checks = 0;
    int failures = 0;

    logic [63:0] in_q[$];
    logic [63:0] out_q[$];
    logic [63:0] tx_m;
    logic        ovf_m;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] msk(input int n);
        logic [31:0] m;
        m = '1;
        if (n < W) m = m << (W - n);
        return m;
    endfunction

    function automatic void adc_model(input logic [63:0] f);
        if (in_q.size() < D) in_q.push_back(f);
        else ovf_m = 1'b1;
    endfunction

    function automatic void dac_model_fall();
        if (out_q.size() > 0) tx_m = out_q.pop_front();
        else tx_m = '0;
    endfunction

    task automatic chk_state();
        check("in_avail", 64'(avail), 64'(in_q.size() != 0));
        check("in_head", {in_l, in_r},
              (in_q.size() != 0) ? in_q[0] : 64'd0);
        check("out_allowed", 64'(allowed), 64'(out_q.size() < D));
`ifdef AUDIO_OVERRUN_FLAG_EN
        check("in_overrun", 64'(overrun), 64'(ovf_m));
`endif
    endtask

    task automatic bpulse(input logic d, output logic q);
        adcdat_d = d;
        repeat (H) @(negedge clk);
        bclk_d = 1'b1;
        q = dacdat;
        repeat (H) @(negedge clk);
        bclk_d = 1'b0;
    endtask

    task automatic send_slot(input logic [31:0] w, input int n,
                             output logic [31:0] cap, output logic ext);
        logic q;
        cap = '0;
        ext = 1'b0;
        bpulse(1'($urandom), q);
        for (int i = 0; i < n; i++) begin
            if (i < W) begin
                bpulse(w[W-1-i], q);
                cap[W-1-i] = q;
            end else begin
                bpulse(1'($urandom), q);
                ext = ext | q;
            end
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                              input int nl, input int nr);
        logic [63:0] exp_tx;
        logic [31:0] cl;
        logic [31:0] cr;
        logic        el;
        logic        er;
        exp_tx = tx_m;
        send_slot(l, nl, cl, el);
        adclrck_d = 1'b1;
        daclrck_d = 1'b1;
        send_slot(r, nr, cr, er);
        adclrck_d = 1'b0;
        daclrck_d = 1'b0;
        check("dac_left", 64'(cl), 64'(exp_tx[63:32] & msk(nl)));
        check("dac_right", 64'(cr), 64'(exp_tx[31:0] & msk(nr)));
        check("dac_tail", 64'(el | er), 64'd0);
        adc_model({l & msk(nl), r & msk(nr)});
        dac_model_fall();
        repeat (6) @(negedge clk);
    endtask

    task automatic codec_start();
        adclrck_d = 1'b1;
        daclrck_d = 1'b1;
        repeat (2 * H) @(negedge clk);
        adclrck_d = 1'b0;
        daclrck_d = 1'b0;
        dac_model_fall();
        repeat (6) @(negedge clk);
    endtask

    task automatic read_in();
        @(negedge clk);
        read_in_r = 1'b1;
        @(negedge clk);
        read_in_r = 1'b0;
        if (in_q.size() > 0) void'(in_q.pop_front());
    endtask

    task automatic write_out(input logic [31:0] l, input logic [31:0] r);
        @(negedge clk);
        out_l = l;
        out_r = r;
        write_out_r = 1'b1;
        @(negedge clk);
        write_out_r = 1'b0;
        if (out_q.size() < D) out_q.push_back({l, r});
    endtask

    task automatic xck_check();
        logic prev;
        int   last;
        int   per;
        int   hi;
        last = -1;
        per = 0;
        hi = 0;
        prev = xck;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (xck) hi++;
            if (xck && !prev) begin
                if (last >= 0 && per == 0) per = c - last;
                last = c;
            end
            prev = xck;
        end
        check("xck_period", 64'(per), 64'd4);
        check("xck_high", 64'(hi), 64'd8);
    endtask

    initial begin
        int lens[4];
        logic q;
        lens = '{32, 20, 32, 36};
        rst_n = 1'b0;
        clear_in = 1'b0;
        read_in_r = 1'b0;
        clear_out = 1'b0;
        out_l = '0;
        out_r = '0;
        write_out_r = 1'b0;
        adcdat_d = 1'b0;
        bclk_d = 1'b0;
        adclrck_d = 1'b1;
        daclrck_d = 1'b1;
        tx_m = '0;
        ovf_m = 1'b0;

        repeat (4) @(negedge clk);
        check("rst_avail", 64'(avail), 64'd0);
        check("rst_allowed", 64'(allowed), 64'd1);
        check("rst_dacdat", 64'(dacdat), 64'd0);
        check("rst_xck", 64'(xck), 64'd0);
        check("rst_head", {in_l, in_r}, 64'd0);
        rst_n = 1'b1;
        xck_check();

        write_out(32'hA5A5A5A5, 32'h0F0F0F0F);
        codec_start();
        check("dac_loaded", tx_m, 64'hA5A5A5A5_0F0F0F0F);
        send_frame(32'h12345678, 32'h9ABCDEF0, 32, 32);
        check("adc_fixed", {in_l, in_r}, 64'h12345678_9ABCDEF0);
        chk_state();
        read_in();
        check("avail_after_read", 64'(avail), 64'd0);
        chk_state();
        send_frame($urandom, $urandom, 32, 32);
        chk_state();

        for (int k = 0; k < 12; k++) begin
            int nw;
            int nrd;
            nw = $urandom_range(0, 2);
            nrd = $urandom_range(0, 2);
            repeat (nw) write_out($urandom, $urandom);
            repeat (nrd) begin
                chk_state();
                read_in();
            end
            send_frame($urandom, $urandom,
                       lens[$urandom_range(0, 3)],
                       lens[$urandom_range(0, 3)]);
            chk_state();
        end

        @(negedge clk);
        clear_in = 1'b1;
        clear_out = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        clear_out = 1'b0;
        in_q.delete();
        out_q.delete();
        ovf_m = 1'b0;
        chk_state();

        codec_start();
        repeat (9) write_out($urandom, $urandom);
        check("full_allowed", 64'(allowed), 64'd0);
        chk_state();
        repeat (9) send_frame($urandom, $urandom, 32, 32);
        chk_state();
        repeat (8) begin
            chk_state();
            read_in();
        end
        chk_state();
        repeat (8) send_frame($urandom, $urandom, 32, 32);
        chk_state();

        @(negedge clk);
        clear_in = 1'b1;
        read_in_r = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        read_in_r = 1'b0;
        in_q.delete();
        ovf_m = 1'b0;
        check("flush_avail", 64'(avail), 64'd0);
        chk_state();

        codec_start();
        repeat (8) write_out(32'hFFFFFFFF, 32'hFFFFFFFF);
        chk_state();
        send_frame($urandom, $urandom, 32, 32);
        write_out(32'hFFFFFFFF, 32'hFFFFFFFF);
        chk_state();
        bpulse(1'b0, q);
        repeat (3) bpulse(1'($urandom), q);
        check("dac_mid", 64'(q), 64'(tx_m[63]));
        rst_n = 1'b0;
        #1;
        check("mid_rst_avail", 64'(avail), 64'd0);
        check("mid_rst_allowed", 64'(allowed), 64'd1);
        check("mid_rst_dacdat", 64'(dacdat), 64'd0);
        check("mid_rst_xck", 64'(xck), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        xck_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
